// File: rtl/rd_ptr_ctrl_lvl_if.sv
// Read-side FIFO pointer controller bus: request/threshold inputs and
// pointer, address and status outputs, grouped for the read clock domain.
interface rd_ptr_ctrl_lvl_if #(
  parameter int ADDR_SIZE = 4
);
  logic                 rinc;
  logic [ADDR_SIZE:0]   rq2_wptr;
  logic [ADDR_SIZE:0]   rae_thresh;
  logic                 ruf_clr;
  logic [ADDR_SIZE-1:0] raddr;
  logic [ADDR_SIZE:0]   rptr;
  logic                 rd_en;
  logic                 rempty;
  logic                 raempty;
  logic [ADDR_SIZE:0]   rcount;
  logic                 runderflow;

  // Side that drives requests and observes status (client / bench).
  modport master (
    output rinc, rq2_wptr, rae_thresh, ruf_clr,
    input  raddr, rptr, rd_en, rempty, raempty, rcount, runderflow
  );

  // Side implemented by the pointer controller.
  modport slave (
    input  rinc, rq2_wptr, rae_thresh, ruf_clr,
    output raddr, rptr, rd_en, rempty, raempty, rcount, runderflow
  );
endinterface

// File: rtl/rd_ptr_ctrl_lvl.sv
// Read-side pointer/flag controller for an async FIFO.
// Holds binary and gray read pointers, a registered empty flag, the
// occupancy count, a programmable almost-empty flag and a sticky underflow.
module rd_ptr_ctrl_lvl #(
  parameter int ADDR_SIZE = 4
) (
  input logic              rclk,
  input logic              rrst,
  rd_ptr_ctrl_lvl_if.slave bus
);
  localparam int PW = ADDR_SIZE + 1;

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic [PW-1:0] rcount_q, rcount_d;
  logic [PW-1:0] wbin_s;
  logic          rempty_q, rempty_d;
  logic          raempty_q, raempty_d;
  logic          ruf_q, ruf_d;
  logic          pop_s;

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Next-state pointers, count and flags; a read while empty never advances.
  always_comb begin
    pop_s     = bus.rinc & ~rempty_q;
    rbin_d    = rbin_q + {{ADDR_SIZE{1'b0}}, pop_s};
    rgray_d   = rbin_d ^ (rbin_d >> 1);
    wbin_s    = gray2bin(bus.rq2_wptr);
    // Modulo subtraction with the MSB as wrap bit yields 0..2**ADDR_SIZE.
    rcount_d  = wbin_s - rbin_d;
    rempty_d  = (rgray_d == bus.rq2_wptr);
    raempty_d = (rcount_d <= bus.rae_thresh);
    // A new underflow takes priority over a clear on the same edge.
    if (bus.rinc & rempty_q) begin
      ruf_d = 1'b1;
    end else if (bus.ruf_clr) begin
      ruf_d = 1'b0;
    end else begin
      ruf_d = ruf_q;
    end
  end

  // State registers; reset forces the FIFO to look empty immediately.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q    <= {PW{1'b0}};
      rgray_q   <= {PW{1'b0}};
      rcount_q  <= {PW{1'b0}};
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      ruf_q     <= 1'b0;
    end else begin
      rbin_q    <= rbin_d;
      rgray_q   <= rgray_d;
      rcount_q  <= rcount_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
      ruf_q     <= ruf_d;
    end
  end

  assign bus.raddr      = rbin_q[ADDR_SIZE-1:0];
  assign bus.rptr       = rgray_q;
  assign bus.rd_en      = pop_s;
  assign bus.rempty     = rempty_q;
  assign bus.raempty    = raempty_q;
  assign bus.rcount     = rcount_q;
  assign bus.runderflow = ruf_q;
endmodule

// File: tb/tb_rd_ptr_ctrl_lvl.sv
// Self-checking bench for rd_ptr_ctrl_lvl (ADDR_SIZE=4).
// Table-driven vectors plus hand sequences for full drain, wrap and reset.
module tb_rd_ptr_ctrl_lvl;
  logic rclk;
  logic rrst;

  rd_ptr_ctrl_lvl_if #(.ADDR_SIZE(4)) bus ();

  rd_ptr_ctrl_lvl #(.ADDR_SIZE(4)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  typedef struct {
    logic       rinc;
    logic       clr;
    logic [4:0] wbin;
    logic [4:0] th;
    logic       e_rden;
    logic       e_empty;
    logic       e_ae;
    logic [4:0] e_cnt;
    logic       e_uf;
    logic [3:0] e_raddr;
    logic [4:0] e_rptr;
  } vec_t;

  vec_t vecs[14];
  vec_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Free-running read clock.
  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic vec_t mk(input logic rinc, input logic clr, input logic [4:0] wbin,
                              input logic [4:0] th, input logic rden, input logic empty,
                              input logic ae, input logic [4:0] cnt, input logic uf,
                              input logic [3:0] raddr, input logic [4:0] rptr);
    vec_t v;
    v.rinc = rinc; v.clr = clr; v.wbin = wbin; v.th = th;
    v.e_rden = rden; v.e_empty = empty; v.e_ae = ae; v.e_cnt = cnt;
    v.e_uf = uf; v.e_raddr = raddr; v.e_rptr = rptr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one vector at negedge, check rd_en, score outputs after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge rclk);
    bus.rinc       = v.rinc;
    bus.ruf_clr    = v.clr;
    bus.rq2_wptr   = b2g(v.wbin);
    bus.rae_thresh = v.th;
    #1;
    chk("rd_en", {31'd0, bus.rd_en}, {31'd0, v.e_rden});
    sbq.push_back(v);
    @(posedge rclk);
    #1;
    e = sbq.pop_front();
    chk("rempty",     {31'd0, bus.rempty},     {31'd0, e.e_empty});
    chk("raempty",    {31'd0, bus.raempty},    {31'd0, e.e_ae});
    chk("rcount",     {27'd0, bus.rcount},     {27'd0, e.e_cnt});
    chk("runderflow", {31'd0, bus.runderflow}, {31'd0, e.e_uf});
    chk("raddr",      {28'd0, bus.raddr},      {28'd0, e.e_raddr});
    chk("rptr",       {27'd0, bus.rptr},       {27'd0, e.e_rptr});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rempty"},     {31'd0, bus.rempty},     32'd1);
    chk({tag, "_raempty"},    {31'd0, bus.raempty},    32'd1);
    chk({tag, "_rcount"},     {27'd0, bus.rcount},     32'd0);
    chk({tag, "_rptr"},       {27'd0, bus.rptr},       32'd0);
    chk({tag, "_raddr"},      {28'd0, bus.raddr},      32'd0);
    chk({tag, "_runderflow"}, {31'd0, bus.runderflow}, 32'd0);
  endtask

  initial begin
    logic [4:0] nb;
    logic [4:0] cnt;

    // rinc clr wbin th | rd_en empty ae cnt uf raddr rptr
    vecs[0]  = mk(1'b0, 1'b0, 5'd3,  5'd2,  1'b0, 1'b0, 1'b0, 5'd3,  1'b0, 4'd0, 5'd0);
    vecs[1]  = mk(1'b1, 1'b0, 5'd3,  5'd2,  1'b1, 1'b0, 1'b1, 5'd2,  1'b0, 4'd1, 5'd1);
    vecs[2]  = mk(1'b1, 1'b0, 5'd3,  5'd2,  1'b1, 1'b0, 1'b1, 5'd1,  1'b0, 4'd2, 5'd3);
    vecs[3]  = mk(1'b1, 1'b0, 5'd3,  5'd2,  1'b1, 1'b1, 1'b1, 5'd0,  1'b0, 4'd3, 5'd2);
    vecs[4]  = mk(1'b1, 1'b0, 5'd3,  5'd2,  1'b0, 1'b1, 1'b1, 5'd0,  1'b1, 4'd3, 5'd2);
    vecs[5]  = mk(1'b0, 1'b0, 5'd3,  5'd2,  1'b0, 1'b1, 1'b1, 5'd0,  1'b1, 4'd3, 5'd2);
    vecs[6]  = mk(1'b1, 1'b1, 5'd3,  5'd2,  1'b0, 1'b1, 1'b1, 5'd0,  1'b1, 4'd3, 5'd2);
    vecs[7]  = mk(1'b0, 1'b1, 5'd3,  5'd2,  1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 4'd3, 5'd2);
    vecs[8]  = mk(1'b0, 1'b0, 5'd4,  5'd0,  1'b0, 1'b0, 1'b0, 5'd1,  1'b0, 4'd3, 5'd2);
    vecs[9]  = mk(1'b1, 1'b0, 5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 5'd1,  1'b0, 4'd4, 5'd6);
    vecs[10] = mk(1'b1, 1'b0, 5'd5,  5'd0,  1'b1, 1'b1, 1'b1, 5'd0,  1'b0, 4'd5, 5'd7);
    vecs[11] = mk(1'b0, 1'b0, 5'd6,  5'd16, 1'b0, 1'b0, 1'b1, 5'd1,  1'b0, 4'd5, 5'd7);
    vecs[12] = mk(1'b0, 1'b0, 5'd21, 5'd31, 1'b0, 1'b0, 1'b1, 5'd16, 1'b0, 4'd5, 5'd7);
    vecs[13] = mk(1'b0, 1'b0, 5'd21, 5'd2,  1'b0, 1'b0, 1'b0, 5'd16, 1'b0, 4'd5, 5'd7);

    // Power-on reset with idle inputs.
    rrst           = 1'b1;
    bus.rinc       = 1'b0;
    bus.ruf_clr    = 1'b0;
    bus.rq2_wptr   = 5'd0;
    bus.rae_thresh = 5'd2;
    #1;
    chk_reset_state("por");
    @(negedge rclk);
    rrst = 1'b0;

    // Fill/drain, underflow set/clear, threshold 0, simultaneous pop+write, full.
    for (int i = 0; i < 14; i++) begin
      apply(vecs[i]);
    end

    // Full FIFO (rbin=5, wbin=21): 16 pops drain to empty.
    for (int k = 0; k < 16; k++) begin
      nb  = 5'(6 + k);
      cnt = 5'(15 - k);
      apply(mk(1'b1, 1'b0, 5'd21, 5'd2, 1'b1, (cnt == 5'd0), (cnt <= 5'd2), cnt,
               1'b0, nb[3:0], b2g(nb)));
    end

    // Advance to rbin=31, then wptr wraps to 0 and one pop wraps rbin to 0.
    apply(mk(1'b0, 1'b0, 5'd31, 5'd2, 1'b0, 1'b0, 1'b0, 5'd10, 1'b0, 4'd5, b2g(5'd21)));
    for (int k = 0; k < 10; k++) begin
      nb  = 5'(22 + k);
      cnt = 5'(9 - k);
      apply(mk(1'b1, 1'b0, 5'd31, 5'd2, 1'b1, (cnt == 5'd0), (cnt <= 5'd2), cnt,
               1'b0, nb[3:0], b2g(nb)));
    end
    apply(mk(1'b0, 1'b0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 4'd15, 5'b10000));
    apply(mk(1'b1, 1'b0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 4'd0,  5'b00000));

    // Set underflow, load 5 words, then reset asynchronously mid-cycle.
    apply(mk(1'b1, 1'b0, 5'd0, 5'd2, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 4'd0, 5'd0));
    apply(mk(1'b0, 1'b0, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 4'd0, 5'd0));
    @(negedge rclk);
    #2;
    rrst = 1'b1;
    #1;
    chk_reset_state("async_rst");
    bus.rq2_wptr = 5'd0;
    @(negedge rclk);
    rrst = 1'b0;
    apply(mk(1'b0, 1'b0, 5'd0, 5'd2, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 4'd0, 5'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
